// File: rtl/dram_arb_pkg.sv
// rtl/dram_arb_pkg.sv - shared types and helpers for the two-port DRAM arbiter
package dram_arb_pkg;

    typedef enum logic {
        DRAM_WR = 1'b0,
        DRAM_RD = 1'b1
    } dram_cmd_t;

    typedef logic arb_id_t;

    localparam int ARB_NREQ = 2;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/master_fifo.sv
// rtl/master_fifo.sv - DRAM request/response FIFO-style interface
interface master_fifo #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128
);
    import dram_arb_pkg::*;

    typedef struct packed {
        dram_cmd_t         cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic clk;
    req_t req;
    logic req_en;
    logic req_rdy;
    rsp_t rsp;
    logic rsp_en;
    logic rsp_rdy;

    modport master (
        output clk, req, req_en, rsp_rdy,
        input  req_rdy, rsp, rsp_en
    );

    modport slave (
        input  clk, req, req_en, rsp_rdy,
        output req_rdy, rsp, rsp_en
    );

endinterface

// File: rtl/arb_order_fifo.sv
// rtl/arb_order_fifo.sv - in-order requester-ID FIFO for outstanding reads
module arb_order_fifo
    import dram_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    rstn,
    input  logic    push,
    input  arb_id_t push_id,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output arb_id_t head
);

    localparam int PW = $clog2(DEPTH);

    arb_id_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin arbiter sharing one DRAM port between two requesters
// Optional perf counters enabled by DRAM_ARB_PERF_EN.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ORDER_DEPTH = 8,
    parameter int ADDR_W      = 27,
    parameter int DATA_W      = 128
) (
    input  logic              clk,
    input  logic              rstn,
    master_fifo.master        fifo,
    input  logic              rq0_valid,
    output logic              rq0_ready,
    input  logic              rq0_cmd,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_data,
    output logic              rs0_valid,
    output logic [DATA_W-1:0] rs0_data,
    input  logic              rq1_valid,
    output logic              rq1_ready,
    input  logic              rq1_cmd,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_data,
    output logic              rs1_valid,
    output logic [DATA_W-1:0] rs1_data,
    output logic              order_err
`ifdef DRAM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_rd0,
    output logic [31:0]       perf_rd1,
    output logic [31:0]       perf_wr0,
    output logic [31:0]       perf_wr1,
    output logic [31:0]       perf_stall
`endif
);

    logic [ARB_NREQ-1:0] elig;
    logic [ARB_NREQ-1:0] grant;
    logic                slot_free;
    arb_id_t             last_grant;
    arb_id_t             grant_id;
    arb_id_t             head_id;
    dram_cmd_t           sel_cmd;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                tag_full;
    logic                tag_empty;
    logic                tag_push;
    logic                tag_pop;

    assign fifo.clk     = clk;
    assign fifo.rsp_rdy = 1'b1;
    assign rq0_ready    = grant[0];
    assign rq1_ready    = grant[1];

    always_comb begin
        slot_free = !fifo.req_en || fifo.req_rdy;
        elig[0]   = rq0_valid && ((dram_cmd_t'(rq0_cmd) == DRAM_WR) || !tag_full);
        elig[1]   = rq1_valid && ((dram_cmd_t'(rq1_cmd) == DRAM_WR) || !tag_full);
        grant     = '0;
        // On a tie, the requester that did not win last time goes first.
        if (slot_free) begin
            if (elig[0] && (!elig[1] || (last_grant == 1'b1))) begin
                grant[0] = 1'b1;
            end else if (elig[1]) begin
                grant[1] = 1'b1;
            end
        end
        grant_id = arb_id_t'(grant[1]);
        sel_cmd  = dram_cmd_t'(grant[1] ? rq1_cmd : rq0_cmd);
        sel_addr = grant[1] ? rq1_addr : rq0_addr;
        sel_data = grant[1] ? rq1_data : rq0_data;
        tag_push = (|grant) && (sel_cmd == DRAM_RD);
        tag_pop  = fifo.rsp_en && !tag_empty;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo.req    <= '0;
            fifo.req_en <= 1'b0;
            last_grant  <= 1'b1;
        end else if (slot_free) begin
            if (|grant) begin
                fifo.req.cmd  <= sel_cmd;
                fifo.req.addr <= sel_addr;
                fifo.req.data <= (sel_cmd == DRAM_RD) ? '0 : sel_data;
                fifo.req_en   <= 1'b1;
                last_grant    <= grant_id;
            end else begin
                fifo.req_en <= 1'b0;
            end
        end
    end

    arb_order_fifo #(
        .DEPTH (ORDER_DEPTH)
    ) u_order (
        .clk     (clk),
        .rstn    (rstn),
        .push    (tag_push),
        .push_id (grant_id),
        .pop     (tag_pop),
        .full    (tag_full),
        .empty   (tag_empty),
        .head    (head_id)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rs0_valid <= 1'b0;
            rs1_valid <= 1'b0;
            rs0_data  <= '0;
            rs1_data  <= '0;
            order_err <= 1'b0;
        end else begin
            rs0_valid <= tag_pop && (head_id == 1'b0);
            rs1_valid <= tag_pop && (head_id == 1'b1);
            if (tag_pop && (head_id == 1'b0)) begin
                rs0_data <= fifo.rsp.data;
            end
            if (tag_pop && (head_id == 1'b1)) begin
                rs1_data <= fifo.rsp.data;
            end
            // A beat with no recorded owner cannot be routed; flag it until reset.
            if (fifo.rsp_en && tag_empty) begin
                order_err <= 1'b1;
            end
        end
    end

`ifdef DRAM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_rd0   <= '0;
            perf_rd1   <= '0;
            perf_wr0   <= '0;
            perf_wr1   <= '0;
            perf_stall <= '0;
        end else begin
            perf_rd0   <= sat_inc(perf_rd0, grant[0] && (sel_cmd == DRAM_RD));
            perf_rd1   <= sat_inc(perf_rd1, grant[1] && (sel_cmd == DRAM_RD));
            perf_wr0   <= sat_inc(perf_wr0, grant[0] && (sel_cmd == DRAM_WR));
            perf_wr1   <= sat_inc(perf_wr1, grant[1] && (sel_cmd == DRAM_WR));
            perf_stall <= sat_inc(perf_stall, (rq0_valid && !grant[0]) || (rq1_valid && !grant[1]));
        end
    end
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - scoreboard testbench for dram_arbiter
module tb_dram_arbiter;

    localparam int AW = 27;
    localparam int DW = 128;

    typedef struct packed {
        logic          cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_req_t;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
    } exp_rsp_t;

    logic          clk;
    logic          rstn;
    logic          rq0_valid, rq0_ready, rq0_cmd;
    logic [AW-1:0] rq0_addr;
    logic [DW-1:0] rq0_data;
    logic          rs0_valid;
    logic [DW-1:0] rs0_data;
    logic          rq1_valid, rq1_ready, rq1_cmd;
    logic [AW-1:0] rq1_addr;
    logic [DW-1:0] rq1_data;
    logic          rs1_valid;
    logic [DW-1:0] rs1_data;
    logic          order_err;
`ifdef DRAM_ARB_PERF_EN
    logic [31:0]   perf_rd0, perf_rd1, perf_wr0, perf_wr1, perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    exp_req_t req_q[$];
    exp_rsp_t rsp_q[$];

    master_fifo #(.ADDR_W(AW), .DATA_W(DW)) fifo_if ();

    dram_arbiter #(.ORDER_DEPTH(8), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .fifo      (fifo_if),
        .rq0_valid (rq0_valid),
        .rq0_ready (rq0_ready),
        .rq0_cmd   (rq0_cmd),
        .rq0_addr  (rq0_addr),
        .rq0_data  (rq0_data),
        .rs0_valid (rs0_valid),
        .rs0_data  (rs0_data),
        .rq1_valid (rq1_valid),
        .rq1_ready (rq1_ready),
        .rq1_cmd   (rq1_cmd),
        .rq1_addr  (rq1_addr),
        .rq1_data  (rq1_data),
        .rs1_valid (rs1_valid),
        .rs1_data  (rs1_data),
        .order_err (order_err)
`ifdef DRAM_ARB_PERF_EN
        ,
        .perf_rd0  (perf_rd0),
        .perf_rd1  (perf_rd1),
        .perf_wr0  (perf_wr0),
        .perf_wr1  (perf_wr1),
        .perf_stall(perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_req(input logic c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_req_t e;
        e.cmd  = c;
        e.addr = a;
        e.data = d;
        req_q.push_back(e);
    endtask

    task automatic send_rsp(input logic id, input logic [DW-1:0] d);
        exp_rsp_t e;
        e.id   = id;
        e.data = d;
        rsp_q.push_back(e);
        fifo_if.rsp_en    = 1'b1;
        fifo_if.rsp.data  = d;
        tick();
        fifo_if.rsp_en    = 1'b0;
    endtask

    task automatic idle_inputs();
        rq0_valid = 1'b0; rq0_cmd = 1'b0; rq0_addr = '0; rq0_data = '0;
        rq1_valid = 1'b0; rq1_cmd = 1'b0; rq1_addr = '0; rq1_data = '0;
        fifo_if.req_rdy  = 1'b1;
        fifo_if.rsp_en   = 1'b0;
        fifo_if.rsp.data = '0;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        idle_inputs();
        tick();
        tick();
        rstn = 1'b1;
        req_q.delete();
        rsp_q.delete();
    endtask

    // Scoreboard monitor: checks every DRAM transfer and every response beat mid-cycle.
    always @(negedge clk) begin
        exp_req_t eq;
        exp_rsp_t es;
        if (rstn) begin
            if (fifo_if.req_en && fifo_if.req_rdy) begin
                if (req_q.size() == 0) begin
                    chkw("req_unexpected", 128'(fifo_if.req.addr), '1);
                end else begin
                    eq = req_q.pop_front();
                    chk1("req_cmd", fifo_if.req.cmd, eq.cmd);
                    chkw("req_addr", 128'(fifo_if.req.addr), 128'(eq.addr));
                    chkw("req_data", fifo_if.req.data, eq.data);
                end
            end
            if (rs0_valid && rs1_valid) begin
                chk1("rs_both_valid", 1'b1, 1'b0);
            end
            if (rs0_valid || rs1_valid) begin
                if (rsp_q.size() == 0) begin
                    chk1("rs_unexpected", rs1_valid, !rs1_valid);
                end else begin
                    es = rsp_q.pop_front();
                    chk1("rs_id", rs1_valid, es.id);
                    chkw("rs_data", rs1_valid ? rs1_data : rs0_data, es.data);
                end
            end
        end
    end

    initial begin
        rstn = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk1("rst_req_en", fifo_if.req_en, 1'b0);
        chk1("rst_req_zero", fifo_if.req == '0, 1'b1);
        chk1("rst_rs0_valid", rs0_valid, 1'b0);
        chk1("rst_rs1_valid", rs1_valid, 1'b0);
        chkw("rst_rs0_data", rs0_data, '0);
        chk1("rst_order_err", order_err, 1'b0);
        chk1("rsp_rdy_tied", fifo_if.rsp_rdy, 1'b1);
        chk1("fifo_clk", fifo_if.clk, clk);
        rstn = 1'b1;
        tick();

        // Single write then read from requester 0
        rq0_valid = 1'b1; rq0_cmd = 1'b0; rq0_addr = 27'h300;
        rq0_data  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        exp_req(1'b0, 27'h300, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        #1 chk1("t1_wr_ready", rq0_ready, 1'b1);
        tick();
        chk1("t1_wr_req_en", fifo_if.req_en, 1'b1);
        chk1("t1_wr_cmd", fifo_if.req.cmd, 1'b0);
        rq0_cmd = 1'b1;
        exp_req(1'b1, 27'h300, '0);
        #1 chk1("t1_rd_ready", rq0_ready, 1'b1);
        tick();
        chk1("t1_rd_cmd", fifo_if.req.cmd, 1'b1);
        chkw("t1_rd_data_zero", fifo_if.req.data, '0);
        rq0_valid = 1'b0;
        tick();
        chk1("t1_req_en_drop", fifo_if.req_en, 1'b0);
        send_rsp(1'b0, 128'hCAFE_0000_0000_0001);
        chk1("t1_rs0_pulse", rs0_valid, 1'b1);
        chk1("t1_rs1_quiet", rs1_valid, 1'b0);
        tick();
        chk1("t1_rs0_single", rs0_valid, 1'b0);

        // Contention: grants alternate starting with requester 0
        apply_reset();
        rq0_valid = 1'b1; rq0_cmd = 1'b1; rq0_addr = 27'h300;
        rq1_valid = 1'b1; rq1_cmd = 1'b1; rq1_addr = 27'h400;
        for (int k = 0; k < 4; k++) begin
            exp_req(1'b1, (k % 2 == 0) ? 27'h300 : 27'h400, '0);
            #1;
            chk1("t2_ready0", rq0_ready, (k % 2 == 0));
            chk1("t2_ready1", rq1_ready, (k % 2 == 1));
            tick();
        end
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        send_rsp(1'b0, 128'hA0);
        send_rsp(1'b1, 128'hA1);
        send_rsp(1'b0, 128'hA2);
        send_rsp(1'b1, 128'hA3);
        tick();

        // Backpressure: held request stays stable while req_rdy is low
        rq0_valid = 1'b1; rq0_cmd = 1'b0; rq0_addr = 27'h500; rq0_data = 128'hB500;
        rq1_valid = 1'b1; rq1_cmd = 1'b0; rq1_addr = 27'h600; rq1_data = 128'hB600;
        fifo_if.req_rdy = 1'b0;
        exp_req(1'b0, 27'h500, 128'hB500);
        exp_req(1'b0, 27'h600, 128'hB600);
        #1 chk1("t3_first_ready0", rq0_ready, 1'b1);
        tick();
        rq0_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk1("t3_hold_req_en", fifo_if.req_en, 1'b1);
            chkw("t3_hold_addr", 128'(fifo_if.req.addr), 128'h500);
            chk1("t3_hold_ready0", rq0_ready, 1'b0);
            chk1("t3_hold_ready1", rq1_ready, 1'b0);
            tick();
        end
        fifo_if.req_rdy = 1'b1;
        #1 chk1("t3_release_ready1", rq1_ready, 1'b1);
        tick();
        rq1_valid = 1'b0;
        tick();
        tick();

        // Full tag FIFO: ninth read stalls while a write still goes through
        rq1_valid = 1'b1; rq1_cmd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rq1_addr = 27'(32'h700 + i);
            exp_req(1'b1, 27'(32'h700 + i), '0);
            #1 chk1("t4_rd_ready", rq1_ready, 1'b1);
            tick();
        end
        rq1_addr  = 27'h708;
        rq0_valid = 1'b1; rq0_cmd = 1'b0; rq0_addr = 27'h800; rq0_data = 128'hC800;
        exp_req(1'b0, 27'h800, 128'hC800);
        exp_req(1'b1, 27'h708, '0);
        #1;
        chk1("t4_full_ready1", rq1_ready, 1'b0);
        chk1("t4_full_wr_ready0", rq0_ready, 1'b1);
        tick();
        rq0_valid = 1'b0;
        #1 chk1("t4_still_full", rq1_ready, 1'b0);
        send_rsp(1'b1, 128'hD0);
        #1 chk1("t4_after_pop_ready1", rq1_ready, 1'b1);
        tick();
        rq1_valid = 1'b0;
        for (int i = 1; i < 9; i++) begin
            send_rsp(1'b1, 128'(32'hD0 + i));
        end
        tick();

        // Spurious response after reset
        apply_reset();
        chk1("t5_err_clear", order_err, 1'b0);
        fifo_if.rsp_en = 1'b1;
        tick();
        fifo_if.rsp_en = 1'b0;
        chk1("t5_err_set", order_err, 1'b1);
        chk1("t5_no_rs0", rs0_valid, 1'b0);
        chk1("t5_no_rs1", rs1_valid, 1'b0);
        tick();
        tick();
        chk1("t5_err_sticky", order_err, 1'b1);

        // Asynchronous reset in the middle of a burst
        rq0_valid = 1'b1; rq0_cmd = 1'b1; rq0_addr = 27'h900;
        rq1_valid = 1'b1; rq1_cmd = 1'b1; rq1_addr = 27'hA00;
        exp_req(1'b1, 27'h900, '0);
        exp_req(1'b1, 27'hA00, '0);
        tick();
        rsp_q.push_back('{id: 1'b0, data: 128'hE900});
        fifo_if.rsp_en = 1'b1; fifo_if.rsp.data = 128'hE900;
        tick();
        fifo_if.rsp_en = 1'b0;
        chk1("t6_pre_rs0", rs0_valid, 1'b1);
        chk1("t6_pre_req_en", fifo_if.req_en, 1'b1);
        #2;
        rstn = 1'b0;
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        #1;
        chk1("t6_async_req_en", fifo_if.req_en, 1'b0);
        chk1("t6_async_rs0", rs0_valid, 1'b0);
        chk1("t6_async_rs1", rs1_valid, 1'b0);
        chk1("t6_async_err", order_err, 1'b0);
        req_q.delete();
        rsp_q.delete();
        tick();
        tick();
        rstn = 1'b1;
        fifo_if.rsp_en = 1'b1;
        tick();
        fifo_if.rsp_en = 1'b0;
        chk1("t6_late_rsp_err", order_err, 1'b1);
        chk1("t6_late_no_rs0", rs0_valid, 1'b0);
        rq0_valid = 1'b1; rq0_cmd = 1'b1; rq0_addr = 27'hB00;
        rq1_valid = 1'b1; rq1_cmd = 1'b1; rq1_addr = 27'hC00;
        exp_req(1'b1, 27'hB00, '0);
        exp_req(1'b1, 27'hC00, '0);
        #1;
        chk1("t6_first_ready0", rq0_ready, 1'b1);
        chk1("t6_first_ready1", rq1_ready, 1'b0);
        tick();
        tick();
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        send_rsp(1'b0, 128'hFB00);
        send_rsp(1'b1, 128'hFC00);
        tick();
        tick();
        tick();

        chk1("end_req_q_drained", req_q.size() == 0, 1'b1);
        chk1("end_rsp_q_drained", rsp_q.size() == 0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
